// File: rtl/lu_mem_pkg.sv
// Shared constants for the lu_processor data-memory arbiter: default widths,
// FSM state encoding and the supported requester count.
package lu_mem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int NREQ_MAX   = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lu_mem_arbiter_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping from NREQ-1 back to 0.
module lu_rr_pick
    import lu_mem_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] winner_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest slot back towards rr_ptr so the nearest requester is written last.
    always_comb begin
        any        = |req;
        winner     = '0;
        winner_idx = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (req[cand]) begin
                winner       = '0;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lu_mem_arbiter.sv
// Round-robin owner of the SyncMEM2P write/read port with optional burst lock;
// read data is routed back one cycle later to the requester that issued it.
module lu_mem_arbiter
    import lu_mem_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy
);

    localparam int         IDX_W      = idx_w(NREQ);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [0:0]                   state;
    logic [IDX_W-1:0]             owner;
    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             next_ptr;
    logic [3:0]                   burst_cnt;

    logic [NREQ-1:0][ADDR_W-1:0]  addr_v;
    logic [NREQ-1:0][DATA_W-1:0]  wdata_v;

    logic                         pick_any;
    logic [NREQ-1:0]              pick_oh;
    logic [IDX_W-1:0]             pick_idx;

    logic                         own_req;
    logic                         own_we;
    logic                         own_lock;
    logic                         release_now;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    lu_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .any        (pick_any),
        .winner     (pick_oh),
        .winner_idx (pick_idx)
    );

    assign own_req  = req[owner];
    assign own_we   = req_we[owner];
    assign own_lock = req_lock[owner];

    // gnt is only nonzero in OWN, so this gating also blocks transfers in IDLE.
    assign mem_en    = own_req & gnt[owner];
    assign mem_we    = mem_en & own_we;
    assign mem_addr  = addr_v[owner];
    assign mem_wdata = wdata_v[owner];

    assign rsp_data  = mem_rdata;
    assign busy      = (state == ST_OWN);

    assign release_now = (state == ST_OWN) &&
                         (!own_req || (mem_en && (!own_lock || burst_cnt == BURST_LAST)));

    assign next_ptr = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
        end else begin
            // One-deep response tag: gnt is the owner's one-hot while a handshake is live.
            rsp_valid <= (mem_en && !own_we) ? gnt : '0;

            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        gnt   <= pick_oh;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (mem_en)
                        burst_cnt <= burst_cnt + 4'd1;
                    if (release_now) begin
                        gnt       <= '0;
                        burst_cnt <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lu_mem_arbiter.sv
// Bench for lu_mem_arbiter: per-requester transaction queues drive the ports,
// a monitor checks arbitration rules, memory muxing and read responses.
`timescale 1ns/100ps
module tb_lu_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;

    typedef struct { logic we; logic lock; logic once; logic [AW-1:0] addr; logic [DW-1:0] wdata; int gap; } txn_t;
    typedef struct { int id; logic [DW-1:0] data; } rsp_t;
    typedef struct { int id; logic we; logic [AW-1:0] addr; } hs_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ-1:0]      req_lock = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      gnt;
    logic                 mem_en, mem_we, busy;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata, mem_rdata, rsp_data;
    logic [NREQ-1:0]      rsp_valid;

    lu_mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory model with 1-cycle read latency.
    logic [DW-1:0] mem_arr [16];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) mem_arr[k] <= '0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    txn_t            txq [NREQ][$];
    logic [NREQ-1:0] present = '0;
    int              gapc [NREQ];
    logic [NREQ-1:0] drv_hs = '0;
    logic [DW-1:0]   ref_mem [16];
    rsp_t            expq [$];

    hs_t             hs_log [$];
    int              gnt_log [$];
    logic [DW-1:0]   rsp_d [NREQ][$];
    int              rsp_c [NREQ][$];

    logic [NREQ-1:0] p_gnt = '0, p_req = '0, p_lock = '0;
    logic            p_hs = 1'b0;
    int              burst = 0;
    int              mptr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic txn_t mk(input logic we, input logic lock, input logic once,
                                input int addr, input int wdata, input int gap);
        txn_t t;
        t.we = we; t.lock = lock; t.once = once;
        t.addr = AW'(addr); t.wdata = DW'(wdata); t.gap = gap;
        return t;
    endfunction

    // Driver: present queue heads, retire them on handshake, record expected read data.
    initial begin
        for (int i = 0; i < NREQ; i++) gapc[i] = 0;
        for (int k = 0; k < 16; k++) ref_mem[k] = '0;
        forever begin
            txn_t t;
            rsp_t e;
            @(negedge clk);
            drv_hs = req & gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (present[i] && (drv_hs[i] || txq[i][0].once)) begin
                    t = txq[i].pop_front();
                    present[i] = 1'b0;
                    if (drv_hs[i]) begin
                        if (t.we) ref_mem[t.addr] = t.wdata;
                        else begin
                            e.id = i; e.data = ref_mem[t.addr];
                            expq.push_back(e);
                        end
                    end
                end
                if (!present[i] && txq[i].size() != 0) begin
                    if (gapc[i] >= txq[i][0].gap) begin present[i] = 1'b1; gapc[i] = 0; end
                    else gapc[i]++;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                req[i]                 = present[i];
                req_we[i]              = present[i] ? txq[i][0].we   : 1'b0;
                req_lock[i]            = present[i] ? txq[i][0].lock : 1'b0;
                req_addr[i*AW +: AW]   = present[i] ? txq[i][0].addr : '0;
                req_wdata[i*DW +: DW]  = present[i] ? txq[i][0].wdata : '0;
            end
        end
    end

    // Monitor: arbitration model from the rules, memory mux checks, response scoreboard.
    initial begin
        forever begin
            logic [NREQ-1:0] exp_g;
            logic            hs, found;
            int              o, po, idx;
            hs_t             h;
            rsp_t            e;
            @(negedge clk);
            cyc++;
            if (!rst) begin
                exp_g = '0;
                if (p_gnt == '0) begin
                    found = 1'b0;
                    for (int k = 0; k < NREQ; k++) begin
                        idx = (mptr + k) % NREQ;
                        if (!found && p_req[idx]) begin exp_g = oh(idx); found = 1'b1; end
                    end
                end else begin
                    po = oh2i(p_gnt);
                    if (!p_req[po] || (p_hs && (!p_lock[po] || burst == MB))) mptr = (po + 1) % NREQ;
                    else exp_g = p_gnt;
                end
                check("gnt", 32'(gnt), 32'(exp_g));
                check("busy", 32'(busy), 32'(gnt != '0));
                hs = |(req & gnt);
                check("mem_en", 32'(mem_en), 32'(hs));
                if (hs) begin
                    o = oh2i(gnt);
                    check("mem_we", 32'(mem_we), 32'(req_we[o]));
                    check("mem_addr", 32'(mem_addr), 32'(req_addr[o*AW +: AW]));
                    if (req_we[o]) check("mem_wdata", 32'(mem_wdata), 32'(req_wdata[o*DW +: DW]));
                    h.id = o; h.we = req_we[o]; h.addr = req_addr[o*AW +: AW];
                    hs_log.push_back(h);
                end
                if (p_gnt == '0 && gnt != '0) begin gnt_log.push_back(oh2i(gnt)); burst = 0; end
                if (hs) burst++;
                check("rsp_present", 32'(rsp_valid != '0), 32'(expq.size() != 0));
                if (rsp_valid != '0 && expq.size() != 0) begin
                    e = expq.pop_front();
                    check("rsp_id", 32'(rsp_valid), 32'(oh(e.id)));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    rsp_d[e.id].push_back(rsp_data);
                    rsp_c[e.id].push_back(cyc);
                end
                p_gnt = gnt; p_req = req; p_lock = req_lock; p_hs = hs;
            end
        end
    end

    task automatic clear_logs();
        hs_log.delete();
        gnt_log.delete();
        for (int i = 0; i < NREQ; i++) begin rsp_d[i].delete(); rsp_c[i].delete(); end
    endtask

    task automatic wait_idle(input int limit);
        int  n;
        logic q_empty;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            q_empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (txq[i].size() != 0) q_empty = 1'b0;
            if (q_empty && present == '0 && gnt == '0 && !busy && expq.size() == 0) break;
            n++;
            if (n >= limit) begin
                total++; bad++;
                $display("FAIL idle_timeout: still active after %0d cycles, want idle", limit);
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids4[7];
        int ads4[7];
        ids4 = '{1, 1, 1, 1, 0, 1, 1};
        ads4 = '{0, 1, 2, 3, 0, 4, 5};

        // Reset state.
        #11;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rsp", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        #1 rst = 1'b0;
        @(negedge clk); #1;

        // Single write, then read it back from the other requester.
        clear_logs();
        txq[0].push_back(mk(1, 0, 0, 3, 8'hA5, 0));
        wait_idle(50);
        check("wr_hs_n", hs_log.size(), 1);
        if (hs_log.size() == 1) begin
            check("wr_hs_id", hs_log[0].id, 0);
            check("wr_hs_we", 32'(hs_log[0].we), 1);
            check("wr_hs_addr", 32'(hs_log[0].addr), 3);
        end
        clear_logs();
        txq[1].push_back(mk(0, 0, 0, 3, 0, 0));
        wait_idle(50);
        check("rd_rsp_n", rsp_d[1].size(), 1);
        if (rsp_d[1].size() == 1) check("rd_rsp_data", 32'(rsp_d[1][0]), 32'hA5);

        // Contention, unlocked: strict alternation starting at requester 0.
        clear_logs();
        txq[0].push_back(mk(1, 0, 0, 8, 8'h21, 0));
        txq[0].push_back(mk(1, 0, 0, 9, 8'h22, 0));
        txq[1].push_back(mk(0, 0, 0, 3, 0, 0));
        txq[1].push_back(mk(0, 0, 0, 3, 0, 0));
        wait_idle(60);
        check("cont_gnt_n", gnt_log.size(), 4);
        check("cont_hs_n", hs_log.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < gnt_log.size()) check("cont_gnt_order", gnt_log[k], k % 2);

        // Locked burst from requester 1 with requester 0 pending.
        clear_logs();
        for (int a = 0; a < 6; a++) txq[1].push_back(mk(1, 1, 0, a, 8'h40 + a, 0));
        @(negedge clk); #1;
        txq[0].push_back(mk(0, 0, 0, 0, 0, 0));
        wait_idle(80);
        check("burst_hs_n", hs_log.size(), 7);
        for (int k = 0; k < 7; k++)
            if (k < hs_log.size()) begin
                check("burst_hs_id", hs_log[k].id, ids4[k]);
                check("burst_hs_addr", 32'(hs_log[k].addr), ads4[k]);
            end
        check("burst_gnt_n", gnt_log.size(), 3);
        if (rsp_d[0].size() == 1) check("burst_rd_data", 32'(rsp_d[0][0]), 32'h40);
        else check("burst_rd_n", rsp_d[0].size(), 1);

        // Pipelined locked reads of preloaded words.
        for (int a = 0; a < 3; a++) txq[0].push_back(mk(1, 0, 0, a, 8'h10 + a, 0));
        wait_idle(60);
        clear_logs();
        for (int a = 0; a < 3; a++) txq[0].push_back(mk(0, 1, 0, a, 0, 0));
        wait_idle(60);
        check("pipe_rsp_n", rsp_d[0].size(), 3);
        if (rsp_d[0].size() == 3) begin
            for (int k = 0; k < 3; k++) check("pipe_rsp_data", 32'(rsp_d[0][k]), 32'h10 + k);
            check("pipe_rsp_gap1", rsp_c[0][1] - rsp_c[0][0], 1);
            check("pipe_rsp_gap2", rsp_c[0][2] - rsp_c[0][1], 1);
        end
        check("pipe_gnt_n", gnt_log.size(), 1);

        // Withdrawn request: granted once, no transfer, pointer moves past it.
        clear_logs();
        txq[1].push_back(mk(0, 0, 1, 0, 0, 0));
        wait_idle(30);
        check("wd_gnt_n", gnt_log.size(), 1);
        if (gnt_log.size() == 1) check("wd_gnt_id", gnt_log[0], 1);
        check("wd_hs_n", hs_log.size(), 0);
        clear_logs();
        txq[0].push_back(mk(0, 0, 0, 1, 0, 0));
        txq[1].push_back(mk(0, 0, 0, 2, 0, 0));
        wait_idle(40);
        if (gnt_log.size() >= 1) check("wd_next_gnt", gnt_log[0], 0);
        else check("wd_next_gnt_n", gnt_log.size(), 2);

        // Reset mid-burst.
        for (int a = 10; a < 14; a++) txq[0].push_back(mk(1, 1, 0, a, a, 0));
        begin
            int n;
            n = 0;
            while (gnt[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            check("rst_burst_started", 32'(gnt[0]), 1);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin txq[i].delete(); gapc[i] = 0; end
        present = '0; drv_hs = '0; req = '0; req_lock = '0; req_we = '0;
        expq.delete();
        for (int k = 0; k < 16; k++) ref_mem[k] = '0;
        p_gnt = '0; p_req = '0; p_lock = '0; p_hs = 1'b0; mptr = 0; burst = 0;
        #1;
        check("mrst_gnt", 32'(gnt), 0);
        check("mrst_rsp", 32'(rsp_valid), 0);
        check("mrst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk); #1;
        clear_logs();
        txq[0].push_back(mk(0, 0, 0, 5, 0, 0));
        txq[1].push_back(mk(0, 0, 0, 6, 0, 0));
        wait_idle(40);
        if (gnt_log.size() >= 1) check("mrst_first_gnt", gnt_log[0], 0);
        else check("mrst_gnt_n", gnt_log.size(), 2);

        // Randomized traffic against the running model.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREQ; i++)
                for (int k = 0; k < 25; k++)
                    txq[i].push_back(mk($urandom_range(0, 1), $urandom_range(0, 1),
                                        ($urandom_range(0, 9) == 0), $urandom_range(0, 15),
                                        $urandom_range(0, 255), $urandom_range(0, 3)));
            wait_idle(2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
